// File: rtl/reg_trace_buffer.sv
// Circular history of v0/v1 display pairs with LIVE/BROWSE viewing.
// Ports: Clk, Reset, SampleEn, V0In, V1In, BtnPrev, BtnNext in;
//        Disp0, Disp1, Count, Offset, Live out.
//        Define TRACE_DEDUP_EN to skip capturing repeated pairs.
module reg_trace_buffer #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              SampleEn,
  input  logic [DATA_W-1:0] V0In,
  input  logic [DATA_W-1:0] V1In,
  input  logic              BtnPrev,
  input  logic              BtnNext,
  output logic [DATA_W-1:0] Disp0,
  output logic [DATA_W-1:0] Disp1,
  output logic [PTR_W:0]    Count,
  output logic [PTR_W-1:0]  Offset,
  output logic              Live
);

  localparam int PW = 2 * DATA_W;
  localparam logic [PTR_W:0]   FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] P_ONE = PTR_W'(1);

  typedef enum logic {
    S_LIVE,
    S_BROWSE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] offset_q, offset_d;
  logic [PW-1:0]    disp_q, disp_d;
  logic             prev_btn_q, next_btn_q;
  logic [PTR_W-1:0] rd_idx;
  logic [PW-1:0]    pair;
  logic             prev_e, next_e;
  logic             solo_prev, solo_next;
  logic             differs, cap;

`ifdef TRACE_DEDUP_EN
  logic [PW-1:0] last_q;
`endif

  always_comb begin
    pair      = {V0In, V1In};
    prev_e    = BtnPrev & ~prev_btn_q;
    next_e    = BtnNext & ~next_btn_q;
    solo_prev = prev_e & ~next_e;
    solo_next = next_e & ~prev_e;
`ifdef TRACE_DEDUP_EN
    differs = (count_q == '0) || (pair != last_q);
`else
    differs = 1'b1;
`endif
    cap = (state_q == S_LIVE) && SampleEn && differs;

    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    offset_d = offset_q;

    if (cap) begin
      wr_ptr_d = wr_ptr_q + P_ONE;
      if (count_q != FULL) count_d = count_q + C_ONE;
    end

    unique case (state_q)
      S_LIVE: begin
        // Uses post-capture count so a same-cycle capture can be browsed
        if (solo_prev && count_d != '0) begin
          state_d  = S_BROWSE;
          offset_d = '0;
        end
      end
      S_BROWSE: begin
        if (solo_prev) begin
          if ({1'b0, offset_q} < count_q - C_ONE)
            offset_d = offset_q + P_ONE;
        end else if (solo_next) begin
          if (offset_q != '0) offset_d = offset_q - P_ONE;
          else                state_d  = S_LIVE;
        end
      end
      default: state_d = S_LIVE;
    endcase

    rd_idx = wr_ptr_d - P_ONE - offset_d;
    // A capture in the entry cycle is not yet in mem: bypass it
    if (state_d == S_LIVE) disp_d = pair;
    else if (cap)          disp_d = pair;
    else                   disp_d = mem[rd_idx];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_LIVE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      offset_q   <= '0;
      disp_q     <= '0;
      prev_btn_q <= 1'b0;
      next_btn_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      offset_q   <= offset_d;
      disp_q     <= disp_d;
      prev_btn_q <= BtnPrev;
      next_btn_q <= BtnNext;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && cap) mem[wr_ptr_q] <= pair;
  end

`ifdef TRACE_DEDUP_EN
  always_ff @(posedge Clk) begin
    if (Reset)    last_q <= '0;
    else if (cap) last_q <= pair;
  end
`endif

  assign Disp0  = disp_q[PW-1:DATA_W];
  assign Disp1  = disp_q[DATA_W-1:0];
  assign Count  = count_q;
  assign Offset = offset_q;
  assign Live   = (state_q == S_LIVE);

endmodule

// File: doc/reg_trace_buffer.md
Name: reg_trace_buffer

Overview:
- Sits between the Datapath result registers (v0/v1) and the two-by-four-digit display driver.
- Records a history of the 16-bit v0/v1 display pairs, sampled once per divided-clock tick, in a circular buffer.
- In LIVE mode it shows the current values. In BROWSE mode the user steps back through past pairs with two buttons.
- Runs on the fast board clock. The divided-clock tick arrives as a one-Clk-cycle pulse.

Parameters:
- DEPTH, 8, number of history entries; must be a power of two, at least 2.
- PTR_W, 3, log2(DEPTH).
- DATA_W, 16, width of each displayed value.

Ports:
- Clk  input  1  board clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- SampleEn  input  1  one-cycle pulse, one per divided-clock tick.
- V0In  input  DATA_W  current v0 value (low half) from Datapath.
- V1In  input  DATA_W  current v1 value (low half) from Datapath.
- BtnPrev  input  1  debounced level; a rising edge steps to an older entry.
- BtnNext  input  1  debounced level; a rising edge steps to a newer entry or returns to live.
- Disp0  output  DATA_W  value routed to the left display group.
- Disp1  output  DATA_W  value routed to the right display group.
- Count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- Offset  output  PTR_W  age of the displayed entry; 0 = newest; 0 while LIVE.
- Live  output  1  1 = LIVE mode, 0 = BROWSE mode.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: all outputs are 0 except Live=1. Write pointer=0. Button edge registers=0. The "last captured" register is cleared. Buffer contents are don't-care.
- Button edges: a rising edge is BtnX=1 while its registered previous value=0. Edges are detected internally with one register per button.
- Capture rule, in LIVE only, on SampleEn=1:
  - Capture when Count==0, or when {V0In,V1In} differs from the last captured pair (dedup; see Optional Feature).
  - On capture: write at the write pointer, then increment it mod DEPTH (wraps from DEPTH-1 to 0).
  - Count increments and saturates at DEPTH. When full, the oldest entry is overwritten.
- BROWSE freezes the buffer: SampleEn is ignored, and Count and the pointer hold.
- FSM, LIVE state:
  - Disp0/Disp1 are registered copies of V0In/V1In, one cycle of latency.
  - A BtnPrev edge with Count>0 goes to BROWSE with Offset=0.
  - A BtnPrev edge with Count==0 is ignored. BtnNext is ignored.
- FSM, BROWSE state:
  - Displays entry (wr_ptr-1-Offset) mod DEPTH.
  - A BtnPrev edge increments Offset, saturating at Count-1.
  - A BtnNext edge decrements Offset when Offset>0. When Offset==0 it returns to LIVE.
- Simultaneous BtnPrev and BtnNext edges in the same cycle are ignored in both states.
- Display update: Disp0/Disp1 update on the cycle after the event (one-cycle registered read).
- Simultaneous SampleEn and a BtnPrev edge in LIVE: the capture completes first. The new entry becomes Offset 0 in the same cycle BROWSE is entered.
- Reset mid-BROWSE: returns to LIVE with an empty history.

Optional Feature:
- Macro: TRACE_DEDUP_EN.
- Defined: capture only when the pair differs from the last captured pair, or when the buffer is empty.
- Undefined: capture on every SampleEn in LIVE. The last-captured register and its comparator are not built.

Test Plan:
- Reset, then V0In=0x0001, V1In=0x0002, one SampleEn -> Count=1, Live=1, Disp0=0x0001 and Disp1=0x0002 one cycle later.
- With TRACE_DEDUP_EN, three SampleEn pulses with an unchanged pair, then one with V0In=0x0003 -> Count=2. Without the macro, the same stimulus -> Count=4.
- Capture 10 distinct pairs 0x0010..0x0019 (in V0In) -> Count=8. BtnPrev pressed 9 times -> Offset saturates at 7, Disp0=0x0012 (oldest surviving entry).
- In BROWSE at Offset=0, pulse SampleEn with a new pair -> Count unchanged. BtnNext edge -> Live=1, Disp shows the live inputs next cycle.
- BtnPrev and BtnNext rising in the same cycle while LIVE with Count=3 -> no state change. BtnPrev alone with Count=0 -> stays LIVE.
- Reset asserted for one cycle while in BROWSE at Offset=2 -> Live=1, Count=0, Offset=0, Disp0=Disp1=0 on the following cycle.
